// File: rtl/zero_count_accumulator.sv
// zero_count_accumulator: frame statistics over a stream of per-word zero counts
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, frame_len          begin a frame of frame_len words (sampled in IDLE)
//   zc_valid, zc_count        upstream zero count stream
//   zc_ready                  high while accumulating
//   busy                      high in ACCUM or HOLD
//   res_valid, res_ready      result handshake
//   res_sum, res_max          saturated total and largest per-word count
//   res_allzero, res_sat      all-zero word count, saturation flag
module zero_count_accumulator #(
   parameter int WIDTH   = 16,
   parameter int CNT_W   = 5,
   parameter int FRAME_W = 8,
   parameter int SUM_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [FRAME_W-1:0] frame_len,
   input  logic               zc_valid,
   input  logic [CNT_W-1:0]   zc_count,
   output logic               zc_ready,
   output logic               busy,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [SUM_W-1:0]   res_sum,
   output logic [CNT_W-1:0]   res_max,
   output logic [FRAME_W-1:0] res_allzero,
   output logic               res_sat
);
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
   state_t state, state_n;
   logic [FRAME_W-1:0] remaining;
   logic [CNT_W-1:0] cnt;
   logic [SUM_W:0] add;
   logic beat;
   assign zc_ready  = state == ACCUM;
   assign busy      = state != IDLE;
   assign res_valid = state == HOLD;
   always_comb begin
      // out-of-range counts are clamped to a full all-zero word
      cnt = (zc_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : zc_count;
      // one extra bit catches overflow for saturation
      add = {1'b0, res_sum} + (SUM_W+1)'(cnt);
      beat = state == ACCUM && zc_valid;
      state_n = state;
      if (state == IDLE && start)
         state_n = frame_len != '0 ? ACCUM : HOLD;
      else if (beat && remaining == FRAME_W'(1))
         state_n = HOLD;
      else if (state == HOLD && res_ready)
         state_n = IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         remaining   <= '0;
         res_sum     <= '0;
         res_max     <= '0;
         res_allzero <= '0;
         res_sat     <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && start) begin
            remaining   <= frame_len;
            res_sum     <= '0;
            res_max     <= '0;
            res_allzero <= '0;
            res_sat     <= 1'b0;
         end else if (beat) begin
            remaining <= remaining - FRAME_W'(1);
            res_sum   <= add[SUM_W] ? '1 : add[SUM_W-1:0];
            res_sat   <= res_sat | add[SUM_W];
            if (cnt > res_max) res_max <= cnt;
            if (cnt == CNT_W'(WIDTH)) res_allzero <= res_allzero + FRAME_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_zero_count_accumulator.sv
// tb_zero_count_accumulator: directed checks of frame statistics, handshakes and saturation
module tb_zero_count_accumulator;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, zc_valid = 1'b0, res_ready = 1'b0;
   logic [7:0] frame_len = '0;
   logic [4:0] zc_count = '0;
   logic zc_ready, busy, res_valid, res_sat;
   logic [15:0] res_sum;
   logic [4:0] res_max;
   logic [7:0] res_allzero;
   logic s_zc_ready, s_busy, s_res_valid, s_res_sat;
   logic [5:0] s_res_sum;
   logic [4:0] s_res_max;
   logic [7:0] s_res_allzero;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   zero_count_accumulator dut (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
      .zc_valid(zc_valid), .zc_count(zc_count), .zc_ready(zc_ready),
      .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_max(res_max), .res_allzero(res_allzero), .res_sat(res_sat)
   );
   zero_count_accumulator #(.SUM_W(6)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
      .zc_valid(zc_valid), .zc_count(zc_count), .zc_ready(s_zc_ready),
      .busy(s_busy), .res_valid(s_res_valid), .res_ready(res_ready),
      .res_sum(s_res_sum), .res_max(s_res_max), .res_allzero(s_res_allzero), .res_sat(s_res_sat)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic start_frame(input logic [7:0] len);
      start = 1'b1;
      frame_len = len;
      tick();
      start = 1'b0;
   endtask
   task automatic beat(input logic [4:0] c);
      zc_valid = 1'b1;
      zc_count = c;
      tick();
      zc_valid = 1'b0;
   endtask
   task automatic handoff();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask
   task automatic test_reset();
      #12;
      n_chk++;
      if ({zc_ready, busy, res_valid, res_sat} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {zc_ready, busy, res_valid, res_sat}); end
      n_chk++;
      if ({res_sum, res_max, res_allzero} !== 29'd0) begin n_fail++; $display("FAIL reset_results: got %0d/%0d/%0d want 0/0/0", res_sum, res_max, res_allzero); end
      tick();
      rst = 1'b0;
      tick();
   endtask
   task automatic test_reset_midframe();
      start_frame(8);
      beat(5); beat(5); beat(5);
      n_chk++;
      if (res_sum !== 16'd15) begin n_fail++; $display("FAIL midframe_partial: got %0d want 15", res_sum); end
      rst = 1'b1;
      #2;
      n_chk++;
      if ({zc_ready, busy, res_valid, res_sum, res_max} !== 24'd0) begin n_fail++; $display("FAIL midframe_async_reset: got rdy=%b busy=%b v=%b sum=%0d max=%0d want all 0", zc_ready, busy, res_valid, res_sum, res_max); end
      tick();
      rst = 1'b0;
      tick();
      n_chk++;
      if ({busy, res_valid} !== 2'b00) begin n_fail++; $display("FAIL after_reset_idle: got busy=%b v=%b want 0 0", busy, res_valid); end
      start_frame(2);
      beat(4); beat(4);
      n_chk++;
      if (res_valid !== 1'b1 || res_sum !== 16'd8) begin n_fail++; $display("FAIL after_reset_frame: got v=%b sum=%0d want 1 8", res_valid, res_sum); end
      handoff();
   endtask
   task automatic test_basic();
      logic [4:0] c [4] = '{5'd3, 5'd16, 5'd0, 5'd7};
      start_frame(4);
      n_chk++;
      if ({zc_ready, busy} !== 2'b11) begin n_fail++; $display("FAIL basic_accum_flags: got rdy=%b busy=%b want 1 1", zc_ready, busy); end
      zc_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid beat %0d: got %b want 0", i, res_valid); end
         zc_count = c[i];
         tick();
      end
      zc_valid = 1'b0;
      n_chk++;
      if ({res_valid, zc_ready} !== 2'b10) begin n_fail++; $display("FAIL basic_valid_rise: got v=%b rdy=%b want 1 0", res_valid, zc_ready); end
      n_chk++;
      if (res_sum !== 16'd26 || res_max !== 5'd16 || res_allzero !== 8'd1 || res_sat !== 1'b0) begin n_fail++; $display("FAIL basic_results: got %0d/%0d/%0d/%b want 26/16/1/0", res_sum, res_max, res_allzero, res_sat); end
      handoff();
      n_chk++;
      if ({res_valid, busy} !== 2'b00 || res_sum !== 16'd26) begin n_fail++; $display("FAIL basic_idle_keep: got v=%b busy=%b sum=%0d want 0 0 26", res_valid, busy, res_sum); end
   endtask
   task automatic test_backpressure();
      logic [4:0] c [4] = '{5'd3, 5'd16, 5'd0, 5'd7};
      logic [6:0] pat = 7'b1011001;
      int k = 0;
      start_frame(4);
      for (int i = 0; i < 7; i++) begin
         zc_valid = pat[i];
         zc_count = pat[i] ? c[k] : 5'd31;
         if (pat[i]) k++;
         tick();
      end
      zc_valid = 1'b0;
      n_chk++;
      if (res_valid !== 1'b1 || res_sum !== 16'd26 || res_max !== 5'd16 || res_allzero !== 8'd1) begin n_fail++; $display("FAIL bp_results: got v=%b %0d/%0d/%0d want 1 26/16/1", res_valid, res_sum, res_max, res_allzero); end
      for (int i = 0; i < 5; i++) begin
         zc_valid = 1'b1;
         zc_count = 5'd9;
         tick();
         n_chk++;
         if (res_valid !== 1'b1 || res_sum !== 16'd26 || res_max !== 5'd16 || res_allzero !== 8'd1) begin n_fail++; $display("FAIL bp_stall cycle %0d: got v=%b %0d/%0d/%0d want 1 26/16/1", i, res_valid, res_sum, res_max, res_allzero); end
      end
      zc_valid = 1'b0;
      handoff();
      n_chk++;
      if ({res_valid, busy} !== 2'b00 || res_sum !== 16'd26) begin n_fail++; $display("FAIL bp_idle: got v=%b busy=%b sum=%0d want 0 0 26", res_valid, busy, res_sum); end
   endtask
   task automatic test_saturation();
      start_frame(5);
      for (int i = 0; i < 5; i++) beat(5'd16);
      n_chk++;
      if (s_res_sum !== 6'd63 || s_res_sat !== 1'b1 || s_res_allzero !== 8'd5 || s_res_valid !== 1'b1) begin n_fail++; $display("FAIL sat_results: got %0d sat=%b az=%0d v=%b want 63 1 5 1", s_res_sum, s_res_sat, s_res_allzero, s_res_valid); end
      n_chk++;
      if (res_sum !== 16'd80 || res_sat !== 1'b0) begin n_fail++; $display("FAIL sat_wide_nosat: got %0d sat=%b want 80 0", res_sum, res_sat); end
      handoff();
   endtask
   task automatic test_empty_illegal();
      start_frame(0);
      n_chk++;
      if (res_valid !== 1'b1 || res_sum !== 16'd0 || res_max !== 5'd0 || res_allzero !== 8'd0 || res_sat !== 1'b0) begin n_fail++; $display("FAIL empty_frame: got v=%b %0d/%0d/%0d/%b want 1 0/0/0/0", res_valid, res_sum, res_max, res_allzero, res_sat); end
      handoff();
      start_frame(1);
      beat(5'd20);
      n_chk++;
      if (res_valid !== 1'b1 || res_sum !== 16'd16 || res_max !== 5'd16 || res_allzero !== 8'd1) begin n_fail++; $display("FAIL illegal_clamp: got v=%b %0d/%0d/%0d want 1 16/16/1", res_valid, res_sum, res_max, res_allzero); end
      handoff();
   endtask
   task automatic test_overlap();
      zc_valid = 1'b1;
      zc_count = 5'd9;
      tick();
      zc_valid = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || res_sum !== 16'd16) begin n_fail++; $display("FAIL idle_ignore_valid: got busy=%b sum=%0d want 0 16", busy, res_sum); end
      start_frame(2);
      start = 1'b1;
      frame_len = 8'd9;
      beat(5'd3);
      beat(5'd4);
      n_chk++;
      if (res_valid !== 1'b1 || res_sum !== 16'd7) begin n_fail++; $display("FAIL overlap_accum: got v=%b sum=%0d want 1 7", res_valid, res_sum); end
      zc_valid = 1'b1;
      zc_count = 5'd9;
      tick();
      zc_valid = 1'b0;
      n_chk++;
      if (res_valid !== 1'b1 || res_sum !== 16'd7 || res_max !== 5'd4) begin n_fail++; $display("FAIL overlap_hold: got v=%b sum=%0d max=%0d want 1 7 4", res_valid, res_sum, res_max); end
      start = 1'b0;
      handoff();
      start_frame(1);
      n_chk++;
      if (res_sum !== 16'd0 || res_max !== 5'd0 || zc_ready !== 1'b1) begin n_fail++; $display("FAIL overlap_restart_clear: got sum=%0d max=%0d rdy=%b want 0 0 1", res_sum, res_max, zc_ready); end
      beat(5'd2);
      n_chk++;
      if (res_valid !== 1'b1 || res_sum !== 16'd2 || res_max !== 5'd2) begin n_fail++; $display("FAIL overlap_newframe: got v=%b sum=%0d max=%0d want 1 2 2", res_valid, res_sum, res_max); end
      handoff();
   endtask
   initial begin
      test_reset();
      test_basic();
      test_reset_midframe();
      test_backpressure();
      test_saturation();
      test_empty_illegal();
      test_overlap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
